// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit path.
// Pure declarations: no latency, no backpressure.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // A one-clock bit still needs a one-bit counter register.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit <= 1) ? 1 : $clog2(clks_per_bit);
  endfunction

  function automatic int idx_width(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, bit_done pulses on the terminal count.
// Counts only while enabled; no handshake, restart wins over enable.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic bit_done
);

  if (CLKS_PER_BIT < 1) begin : g_cpb_check
    $error("uart_bit_timer: CLKS_PER_BIT must be at least 1");
  end

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = enable && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start, DATA_W bits LSB-first, optional even parity (UART_TX_PARITY_EN), stop.
// tx falls one clock after the handshake; tx_ready is low for the whole frame.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int IW = idx_width(DATA_W);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  uart_tx_state_t    state;
  logic [DATA_W-1:0] shift_reg;
  logic [IW-1:0]     bit_idx;
  logic              bit_done;
  logic              accept;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (busy),
    .restart (accept),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= tx_data;
            bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
            state     <= START;
          end
        end
        START: begin
          if (bit_done) state <= DATA;
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) state <= STOP;
        end
`endif
        STOP: begin
          if (bit_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line level is registered from the current state, so it trails the FSM by one clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx <= parity_bit;
`endif
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
